esp_nibble_tx: RTL and testbench

Transmit path to the ESP32, the counterpart of the nibble receiver on the ExtClk domain. It accepts 12-bit words from the FPGA core (measurement results, status), buffers them in a small FIFO and serialises each word as three 4-bit nibbles. Each nibble carries a 2-bit phase code and a strobe pulse, so the ESP32 reassembles words with the same nibble/phase/pulse scheme the FPGA uses on its receive side. It sits between the measurement/ModeControl logic and the ESP32 GPIO pins.

---
 rtl/esp_link_pkg.sv | 39 +++
 rtl/sync_fifo.sv | 51 +++++
 rtl/esp_nibble_tx.sv | 136 +++++++++++++
 tb/tb_esp_nibble_tx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/esp_link_pkg.sv
// Shared definitions for the ESP32 nibble link (transmit and receive sides).
package esp_link_pkg;

  localparam int WORD_W  = 12;
  localparam int NIB_W   = 4;
  localparam int NIB_CNT = 3;

  localparam logic [1:0] PH_HI   = 2'b00;
  localparam logic [1:0] PH_MID  = 2'b01;
  localparam logic [1:0] PH_LO   = 2'b10;
  localparam logic [1:0] PH_IDLE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_GAP
  } esp_state_t;

  // Nibble index 0 is the most significant nibble.
  function automatic logic [NIB_W-1:0] nib_sel(input logic [WORD_W-1:0] w,
                                               input logic [1:0] idx);
    case (idx)
      2'd0:    nib_sel = w[11:8];
      2'd1:    nib_sel = w[7:4];
      default: nib_sel = w[3:0];
    endcase
  endfunction

  function automatic logic [1:0] phase_of(input logic [1:0] idx);
    case (idx)
      2'd0:    phase_of = PH_HI;
      2'd1:    phase_of = PH_MID;
      default: phase_of = PH_LO;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with show-ahead read data and registered occupancy.
module sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/esp_nibble_tx.sv
// Transmit path to the ESP32: FIFO-buffered 12-bit words sent as three
// phase-coded nibbles, each framed by setup / strobe / hold intervals.
module esp_nibble_tx
  import esp_link_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 4,
  parameter int HOLD_CYC  = 2,
  parameter int GAP_CYC   = 4
) (
  input  logic                   ExtClk,
  input  logic                   ExtReset,
  input  logic [WORD_W-1:0]      TxData,
  input  logic                   TxValid,
  output logic                   TxReady,
  input  logic                   EspBusy,
  output logic [NIB_W-1:0]       NibOut,
  output logic [1:0]             PhaseOut,
  output logic                   PulseOut,
  output logic                   Busy,
  output logic [$clog2(DEPTH):0] Level,
  output logic                   OvfErr
);

  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_HG  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int MAX_CYC = (MAX_SP > MAX_HG) ? MAX_SP : MAX_HG;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  esp_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        idx;
  logic [WORD_W-1:0] word;
  logic [WORD_W-1:0] rd_data;
  logic              full;
  logic              empty;
  logic              pop;

  assign pop     = (state == ST_IDLE) & ~empty & ~EspBusy;
  assign TxReady = ~full;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (ExtClk),
    .rst     (ExtReset),
    .wr_en   (TxValid),
    .wr_data (TxData),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (Level)
  );

  // Full is the pre-edge flag, so a write is flagged even when a pop frees a slot.
  always_ff @(posedge ExtClk) begin
    if (ExtReset)              OvfErr <= 1'b0;
    else if (TxValid && full)  OvfErr <= 1'b1;
  end

  always_ff @(posedge ExtClk) begin
    if (ExtReset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      idx      <= '0;
      word     <= '0;
      NibOut   <= '0;
      PhaseOut <= PH_IDLE;
      PulseOut <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            word     <= rd_data;
            idx      <= '0;
            NibOut   <= nib_sel(rd_data, 2'd0);
            PhaseOut <= phase_of(2'd0);
            cnt      <= CNT_W'(SETUP_CYC - 1);
            Busy     <= 1'b1;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            PulseOut <= 1'b1;
            cnt      <= CNT_W'(PULSE_CYC - 1);
            state    <= ST_PULSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_PULSE: begin
          if (cnt == '0) begin
            PulseOut <= 1'b0;
            cnt      <= CNT_W'(HOLD_CYC - 1);
            state    <= ST_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            if (idx < 2'(NIB_CNT - 1)) begin
              idx      <= idx + 2'd1;
              NibOut   <= nib_sel(word, idx + 2'd1);
              PhaseOut <= phase_of(idx + 2'd1);
              cnt      <= CNT_W'(SETUP_CYC - 1);
              state    <= ST_SETUP;
            end else begin
              NibOut   <= '0;
              PhaseOut <= PH_IDLE;
              cnt      <= CNT_W'(GAP_CYC - 1);
              state    <= ST_GAP;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == '0) begin
            Busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_esp_nibble_tx.sv
// Directed bench for esp_nibble_tx with a pin-level receiver model.
module tb_esp_nibble_tx;

  logic        ExtClk = 1'b0;
  logic        ExtReset = 1'b1;
  logic [11:0] TxData = '0;
  logic        TxValid = 1'b0;
  logic        TxReady;
  logic        EspBusy = 1'b0;
  logic [3:0]  NibOut;
  logic [1:0]  PhaseOut;
  logic        PulseOut;
  logic        Busy;
  logic [2:0]  Level;
  logic        OvfErr;

  int errors = 0;
  int checks = 0;

  always #5 ExtClk = ~ExtClk;

  esp_nibble_tx #(
    .DEPTH     (4),
    .SETUP_CYC (2),
    .PULSE_CYC (4),
    .HOLD_CYC  (2),
    .GAP_CYC   (4)
  ) dut (
    .ExtClk   (ExtClk),
    .ExtReset (ExtReset),
    .TxData   (TxData),
    .TxValid  (TxValid),
    .TxReady  (TxReady),
    .EspBusy  (EspBusy),
    .NibOut   (NibOut),
    .PhaseOut (PhaseOut),
    .PulseOut (PulseOut),
    .Busy     (Busy),
    .Level    (Level),
    .OvfErr   (OvfErr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Receiver model sampled mid-cycle on the falling edge.
  logic [11:0] rx_q[$];
  logic [11:0] exp_q[$];
  logic [11:0] part;
  logic [1:0]  mon_ph = 2'd0;
  logic        prev_pulse = 1'b0;
  logic [5:0]  prev_bus = 6'h30;
  logic [5:0]  latched = '0;
  int          hold_left = 0;
  int          idle_run = 10;
  int          pulses = 0;

  always @(negedge ExtClk) begin
    if (ExtReset) begin
      mon_ph    = 2'd0;
      prev_pulse = 1'b0;
      hold_left = 0;
      idle_run  = 10;
    end else begin
      if (PulseOut && !prev_pulse) begin
        pulses++;
        check("setup_stable", {PhaseOut, NibOut}, prev_bus);
        check("phase_seq", PhaseOut, mon_ph);
        latched = {PhaseOut, NibOut};
        case (PhaseOut)
          2'b00:   part[11:8] = NibOut;
          2'b01:   part[7:4]  = NibOut;
          default: part[3:0]  = NibOut;
        endcase
        if (PhaseOut == 2'b10) begin
          rx_q.push_back(part);
          mon_ph = 2'd0;
        end else begin
          mon_ph = mon_ph + 2'd1;
        end
      end else if (PulseOut) begin
        check("pulse_stable", {PhaseOut, NibOut}, latched);
      end else if (prev_pulse) begin
        hold_left = 1;
        check("hold_stable", {PhaseOut, NibOut}, latched);
      end else if (hold_left > 0) begin
        hold_left--;
        check("hold_stable", {PhaseOut, NibOut}, latched);
      end
      if (PhaseOut == 2'b11) begin
        idle_run++;
      end else begin
        if (prev_bus[5:4] == 2'b11)
          check("gap_len_ok", (idle_run >= 4), 1);
        idle_run = 0;
      end
      prev_pulse = PulseOut;
      prev_bus   = {PhaseOut, NibOut};
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge ExtClk);
    #1;
  endtask

  task automatic push(input logic [11:0] d);
    TxData  = d;
    TxValid = 1'b1;
    @(posedge ExtClk);
    #1;
    TxValid = 1'b0;
  endtask

  task automatic compare_rx(input string tag);
    check({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check({tag, "_word"}, rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    ExtReset = 1'b1;
    step(2);
    ExtReset = 1'b0;
  endtask

  logic [3:0] nb [30];
  logic [1:0] ph [30];
  logic       pl [30];
  logic       bz [30];
  int         pulses_snap;

  initial begin
    step(3);
    ExtReset = 1'b0;
    check("rst_level", Level, 0);
    check("rst_phase", PhaseOut, 2'b11);
    check("rst_nib", NibOut, 0);
    check("rst_pulse", PulseOut, 0);
    check("rst_busy", Busy, 0);
    check("rst_ovf", OvfErr, 0);
    check("rst_ready", TxReady, 1);
    step(2);

    // 1: single word timing
    push(12'hA5C);
    exp_q.push_back(12'hA5C);
    check("t1_level_after_push", Level, 1);
    for (int j = 1; j < 30; j++) begin
      step(1);
      nb[j] = NibOut; ph[j] = PhaseOut; pl[j] = PulseOut; bz[j] = Busy;
    end
    check("t1_nib0", nb[1], 4'hA);
    check("t1_ph0", ph[1], 2'b00);
    check("t1_pulse_pre", pl[2], 0);
    check("t1_pulse_first", pl[3], 1);
    check("t1_pulse_last", pl[6], 1);
    check("t1_pulse_post", pl[7], 0);
    check("t1_ph0_held", ph[8], 2'b00);
    check("t1_nib1", nb[9], 4'h5);
    check("t1_ph1", ph[9], 2'b01);
    check("t1_pulse_nib1", pl[11], 1);
    check("t1_nib2", nb[17], 4'hC);
    check("t1_ph2", ph[17], 2'b10);
    check("t1_gap_ph", ph[25], 2'b11);
    check("t1_gap_nib", nb[25], 0);
    check("t1_busy_in_gap", bz[28], 1);
    check("t1_busy_done", bz[29], 0);
    step(5);
    compare_rx("t1_rx");

    // 2 + 5: fill while ESP busy, then overflow write coinciding with a pop
    EspBusy = 1'b1;
    push(12'h3A1); push(12'h4B2); push(12'h5C3); push(12'h6D4);
    exp_q.push_back(12'h3A1); exp_q.push_back(12'h4B2);
    exp_q.push_back(12'h5C3); exp_q.push_back(12'h6D4);
    check("t2_level_full", Level, 4);
    check("t2_ready_low", TxReady, 0);
    check("t2_no_pulse", PulseOut, 0);
    TxData  = 12'hBAD;
    TxValid = 1'b1;
    EspBusy = 1'b0;
    step(1);
    TxValid = 1'b0;
    check("t5_level_after_pop", Level, 3);
    check("t5_ovf", OvfErr, 1);
    check("t5_ready_back", TxReady, 1);
    check("t5_first_nib", NibOut, 4'h3);
    step(4 * 29 + 10);
    check("t2_ovf_sticky", OvfErr, 1);
    check("t2_busy_idle", Busy, 0);
    compare_rx("t2_rx");

    // 3: EspBusy holds the word in the FIFO
    do_reset();
    check("t3_ovf_cleared", OvfErr, 0);
    EspBusy = 1'b1;
    pulses_snap = pulses;
    push(12'h123);
    exp_q.push_back(12'h123);
    step(6);
    check("t3_level_held", Level, 1);
    check("t3_busy_low", Busy, 0);
    check("t3_pulse_count", pulses, pulses_snap);
    EspBusy = 1'b0;
    step(1);
    check("t3_level_popped", Level, 0);
    check("t3_nib", NibOut, 4'h1);
    check("t3_ph", PhaseOut, 2'b00);
    check("t3_busy", Busy, 1);
    step(35);
    compare_rx("t3_rx");

    // 4: reset during second pulse with words queued
    EspBusy = 1'b1;
    push(12'hFFF); push(12'h111); push(12'h222);
    check("t4_level_queued", Level, 3);
    EspBusy = 1'b0;
    step(1);
    check("t4_level_after_pop", Level, 2);
    step(10);
    check("t4_mid_pulse", PulseOut, 1);
    check("t4_mid_phase", PhaseOut, 2'b01);
    ExtReset = 1'b1;
    step(1);
    check("t4_rst_pulse", PulseOut, 0);
    check("t4_rst_phase", PhaseOut, 2'b11);
    check("t4_rst_level", Level, 0);
    check("t4_rst_ovf", OvfErr, 0);
    check("t4_rst_busy", Busy, 0);
    ExtReset = 1'b0;
    pulses_snap = pulses;
    step(100);
    check("t4_no_output", pulses, pulses_snap);
    check("t4_level_stays", Level, 0);
    compare_rx("t4_rx");

    // 6: streaming with edge checks in the receiver model
    push(12'h000); push(12'hFFF); push(12'h800);
    exp_q.push_back(12'h000); exp_q.push_back(12'hFFF); exp_q.push_back(12'h800);
    step(3 * 29 + 20);
    check("t6_busy_done", Busy, 0);
    compare_rx("t6_rx");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
